// File: rtl/reg_bank_sequencer_pkg.sv
// Shared definitions for the register-bank sequencer: FSM state encodings,
// default parameter values and a helper for index widths.
package reg_bank_sequencer_pkg;

  localparam int N_REQ_DEF      = 4;
  localparam int N_REG_DEF      = 8;
  localparam int DW_DEF         = 8;
  localparam int AW_DEF         = 3;
  localparam int CLR_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_CLEAR   = 3'd4
  } state_e;

  // Width needed to hold an index 0..n-1 (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_bank_sequencer_rr_arbiter.sv
// Round-robin arbiter, purely combinational.
// Ports:
//   req      in  N_REQ  request vector
//   ptr      in  IW     highest-priority requester index
//   gnt_oh   out N_REQ  one-hot winner (all zero when no request)
//   gnt_idx  out IW     winner index
//   gnt_any  out 1      at least one request present
module reg_bank_sequencer_rr_arbiter
  import reg_bank_sequencer_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IW    = idx_width(N_REQ_DEF)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [IW-1:0]    gnt_idx,
  output logic             gnt_any
);

  logic [IW-1:0] cand;

  // Scan requesters starting at ptr, wrapping; first one found wins.
  always_comb begin
    gnt_oh  = {N_REQ{1'b0}};
    gnt_idx = {IW{1'b0}};
    gnt_any = 1'b0;
    cand    = {IW{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      cand = IW'((int'(ptr) + k) % N_REQ);
      if (!gnt_any && req[cand]) begin
        gnt_any      = 1'b1;
        gnt_idx      = cand;
        gnt_oh[cand] = 1'b1;
      end else begin
        gnt_any = gnt_any;
      end
    end
  end

endmodule

// File: rtl/reg_bank_sequencer.sv
// Shares a bank of LS273-style registers between N_REQ requesters. A write
// is granted round robin, the data bus gets one cycle of setup, then a single
// load strobe pulses the addressed register, then done is returned. A clear
// request (checked only in IDLE, priority over writes) holds the bank's
// master-reset low for CLR_CYCLES cycles.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   req/req_addr/req_data  per-requester write request, packed address/data
//   gnt, done, err    per-requester grant/completion, out-of-range address pulse
//   clr_req, clr_busy bank clear request / clear in progress
//   bus_data, reg_load, reg_clr_n  drive the register chips (D, CLK, MR)
//   busy              sequencer not idle
module reg_bank_sequencer
  import reg_bank_sequencer_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int N_REG      = N_REG_DEF,
  parameter int DW         = DW_DEF,
  parameter int AW         = AW_DEF,
  parameter int CLR_CYCLES = CLR_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic                err,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic [DW-1:0]       bus_data,
  output logic [N_REG-1:0]    reg_load,
  output logic                reg_clr_n,
  output logic                busy
);

  localparam int IW = idx_width(N_REQ);
  localparam int CW = idx_width(CLR_CYCLES);

  state_e             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d, win_q, win_d;
  logic [N_REQ-1:0]   win_oh_q, win_oh_d;
  logic [AW-1:0]      addr_q, addr_d, sel_addr;
  logic [DW-1:0]      data_q, data_d, sel_data;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d, done_q, done_d;
  logic [N_REG-1:0]   reg_load_q, reg_load_d;
  logic               err_q, err_d, clr_busy_q, clr_busy_d, busy_q, busy_d;
  logic [N_REQ-1:0]   arb_oh;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;
  logic               in_xfer;

  reg_bank_sequencer_rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  // Select the arbitration winner's address and data slices.
  always_comb begin
    sel_addr = {AW{1'b0}};
    sel_data = {DW{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_idx == IW'(i)) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end else begin
        sel_addr = sel_addr;
      end
    end
  end

  // Next-state logic; outputs are decoded from the next state so that the
  // registered outputs line up with the state they belong to.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    win_oh_d = win_oh_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = CW'(CLR_CYCLES - 1);
        end else if (arb_any) begin
          state_d  = ST_SETUP;
          win_d    = arb_idx;
          win_oh_d = arb_oh;
          addr_d   = sel_addr;
          data_d   = sel_data;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP:   state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_RELEASE;
      ST_RELEASE: begin
        state_d = ST_IDLE;
        ptr_d   = (int'(win_q) == N_REQ - 1) ? {IW{1'b0}} : win_q + IW'(1);
      end
      ST_CLEAR: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_xfer    = (state_d == ST_SETUP) || (state_d == ST_LOAD) || (state_d == ST_RELEASE);
    gnt_d      = in_xfer ? win_oh_d : {N_REQ{1'b0}};
    done_d     = (state_d == ST_RELEASE) ? win_oh_d : {N_REQ{1'b0}};
    err_d      = (state_d == ST_RELEASE) && (int'(addr_d) >= N_REG);
    clr_busy_d = (state_d == ST_CLEAR);
    busy_d     = (state_d != ST_IDLE);
    // Out-of-range addresses match no bit, so no strobe is issued.
    reg_load_d = {N_REG{1'b0}};
    for (int r = 0; r < N_REG; r++) begin
      reg_load_d[r] = (state_d == ST_LOAD) && (int'(addr_d) == r);
    end
  end

  // State, latches and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= {IW{1'b0}};
      win_q      <= {IW{1'b0}};
      win_oh_q   <= {N_REQ{1'b0}};
      addr_q     <= {AW{1'b0}};
      data_q     <= {DW{1'b0}};
      cnt_q      <= {CW{1'b0}};
      gnt_q      <= {N_REQ{1'b0}};
      done_q     <= {N_REQ{1'b0}};
      err_q      <= 1'b0;
      reg_load_q <= {N_REG{1'b0}};
      clr_busy_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      win_oh_q   <= win_oh_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      reg_load_q <= reg_load_d;
      clr_busy_q <= clr_busy_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign clr_busy  = clr_busy_q;
  assign busy      = busy_q;
  assign reg_load  = reg_load_q;
  // The data latch doubles as the bus driver so the bus never floats.
  assign bus_data  = data_q;
  // System reset also clears the bank, without waiting for a clock.
  assign reg_clr_n = rst_n & ~clr_busy_q;

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Scoreboard bench for reg_bank_sequencer (N_REG = 6 so addresses 6/7 are out of range).
module tb_reg_bank_sequencer;

  logic        clk, rst_n, clr_req, err, clr_busy, reg_clr_n, busy;
  logic [3:0]  req, gnt, done;
  logic [11:0] req_addr;
  logic [31:0] req_data;
  logic [7:0]  bus_data;
  logic [5:0]  reg_load;

  reg_bank_sequencer #(.N_REQ(4), .N_REG(6), .DW(8), .AW(3), .CLR_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .clr_req(clr_req), .clr_busy(clr_busy),
    .bus_data(bus_data), .reg_load(reg_load), .reg_clr_n(reg_clr_n), .busy(busy)
  );

  typedef struct packed {
    logic [3:0] oh;
    logic [7:0] data;
    logic [5:0] load;
    logic       err;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [5:0] prev_load = 6'b0;
  logic [7:0] bank [6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int idx, input logic [2:0] a, input logic [7:0] d);
    exp_t e;
    e.oh   = 4'b0001 << idx;
    e.data = d;
    e.err  = (a >= 3'd6);
    e.load = e.err ? 6'b000000 : (6'b000001 << a);
    sb_q.push_back(e);
  endtask

  task automatic wait_gnt(input int idx);
    int c = 0;
    while (gnt[idx] !== 1'b1 && c < 10) begin
      @(negedge clk);
      c++;
    end
    check("gnt_timeout", 32'(gnt[idx]), 32'd1);
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy !== 1'b0 && c < 12) begin
      @(negedge clk);
      c++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic single_write(input int idx, input logic [2:0] a, input logic [7:0] d);
    req_addr[idx*3 +: 3] = a;
    req_data[idx*8 +: 8] = d;
    push_exp(idx, a, d);
    req[idx] = 1'b1;
    wait_gnt(idx);
    req[idx] = 1'b0;
    wait_idle();
  endtask

  // Monitor: scores every done pulse and models the register chips.
  always @(negedge clk) begin
    if (done !== 4'b0000) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got %b expected none", done);
      end else begin
        mon_e = sb_q.pop_front();
        check("done", 32'(done), 32'(mon_e.oh));
        check("gnt_at_done", 32'(gnt), 32'(mon_e.oh));
        check("err", 32'(err), 32'(mon_e.err));
        check("bus_data", 32'(bus_data), 32'(mon_e.data));
        check("load_strobe", 32'(prev_load), 32'(mon_e.load));
      end
    end else if (err !== 1'b0) begin
      check("err_without_done", 32'(err), 32'd0);
    end
    if (reg_clr_n !== 1'b1) begin
      for (int r = 0; r < 6; r++) bank[r] = 8'h00;
    end else begin
      for (int r = 0; r < 6; r++) if (reg_load[r] === 1'b1) bank[r] = bus_data;
    end
    prev_load = reg_load;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_at[8];
    int nd, nclr, nbusy, fd, fc;
    rst_n = 1'b0; req = 4'b0; req_addr = 12'b0; req_data = 32'b0; clr_req = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_load", 32'(reg_load), 32'd0);
    check("rst_bus", 32'(bus_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_clr_busy", 32'(clr_busy), 32'd0);
    check("rst_clr_n", 32'(reg_clr_n), 32'd0);
    rst_n = 1'b1;
    #1 check("rel_clr_n", 32'(reg_clr_n), 32'd1);
    @(negedge clk);

    // Single write, cycle by cycle
    req_addr[2:0] = 3'd5; req_data[7:0] = 8'hA5;
    push_exp(0, 3'd5, 8'hA5);
    req = 4'b0001;
    @(negedge clk);
    check("t1_setup_gnt", 32'(gnt), 32'h1);
    check("t1_setup_bus", 32'(bus_data), 32'hA5);
    check("t1_setup_load", 32'(reg_load), 32'h0);
    check("t1_setup_busy", 32'(busy), 32'd1);
    req = 4'b0000;
    @(negedge clk);
    check("t1_load", 32'(reg_load), 32'b100000);
    check("t1_load_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    check("t1_rel_load", 32'(reg_load), 32'h0);
    @(negedge clk);
    check("t1_idle_gnt", 32'(gnt), 32'h0);
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_idle_bus_hold", 32'(bus_data), 32'hA5);
    check("t1_bank5", 32'(bank[5]), 32'hA5);

    // Reset during LOAD
    req_addr[5:3] = 3'd3; req_data[15:8] = 8'h77;
    req = 4'b0010;
    @(negedge clk);
    check("t5_gnt", 32'(gnt), 32'b0010);
    req = 4'b0000;
    @(negedge clk);
    check("t5_load", 32'(reg_load), 32'b001000);
    #2 rst_n = 1'b0;
    #1;
    check("t5_load_rst", 32'(reg_load), 32'h0);
    check("t5_gnt_rst", 32'(gnt), 32'h0);
    check("t5_bus_rst", 32'(bus_data), 32'h0);
    check("t5_clr_n_rst", 32'(reg_clr_n), 32'd0);
    check("t5_busy_rst", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check("t5_clr_n_hold", 32'(reg_clr_n), 32'd0);
    rst_n = 1'b1;
    #1 check("t5_clr_n_rel", 32'(reg_clr_n), 32'd1);
    @(negedge clk);
    check("t5_bank3", 32'(bank[3]), 32'h0);

    // Contention: pointer back at 0 gives order 0,1,2,3,0
    req_addr = {3'd3, 3'd2, 3'd1, 3'd0};
    req_data = 32'h13121110;
    push_exp(0, 3'd0, 8'h10); push_exp(1, 3'd1, 8'h11); push_exp(2, 3'd2, 8'h12);
    push_exp(3, 3'd3, 8'h13); push_exp(0, 3'd0, 8'h10);
    req = 4'b1111;
    nd = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c == 16) req = 4'b0000;
      if (done !== 4'b0000) begin
        if (nd < 8) done_at[nd] = c;
        nd++;
      end
    end
    check("b2b_count", 32'(nd), 32'd5);
    for (int k = 0; k < 5; k++) check("b2b_spacing", 32'(done_at[k]), 32'(2 + 4*k));

    // Clear and write requested together: clear first, then the write
    req_addr[8:6] = 3'd2; req_data[23:16] = 8'h5A;
    push_exp(2, 3'd2, 8'h5A);
    clr_req = 1'b1; req = 4'b0100;
    nclr = 0; nbusy = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) begin
        clr_req = 1'b0;
        check("t3_clear_first", 32'(clr_busy), 32'd1);
        check("t3_no_gnt", 32'(gnt), 32'h0);
        check("t3_load_zero", 32'(reg_load), 32'h0);
      end
      if (c == 3) req = 4'b0000;
      if (reg_clr_n === 1'b0) nclr++;
      if (clr_busy === 1'b1) nbusy++;
    end
    check("t3_clr_cycles", 32'(nclr), 32'd2);
    check("t3_busy_cycles", 32'(nbusy), 32'd2);
    check("t3_bank2", 32'(bank[2]), 32'h5A);

    // Clear raised mid-write waits for the write to finish
    req_addr[5:3] = 3'd1; req_data[15:8] = 8'hC3;
    push_exp(1, 3'd1, 8'hC3);
    req = 4'b0010;
    wait_gnt(1);
    clr_req = 1'b1; req = 4'b0000;
    fd = -1; fc = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done !== 4'b0000 && fd < 0) fd = c;
      if (clr_busy === 1'b1 && fc < 0) fc = c;
      if (c == 3) clr_req = 1'b0;
    end
    check("t3b_done_cycle", 32'(fd), 32'd1);
    check("t3b_clr_after", 32'(fc), 32'd3);

    // Out-of-range addresses (6 is the first invalid one)
    single_write(3, 3'd7, 8'hE7);
    single_write(0, 3'd6, 8'h66);

    // Requester drops req right after grant; data still lands
    single_write(2, 3'd4, 8'h3C);
    check("t6_bank4", 32'(bank[4]), 32'h3C);
    check("t6_bank1_cleared", 32'(bank[1]), 32'h0);
    check("t6_bank2_cleared", 32'(bank[2]), 32'h0);

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
